cif_req_arb: RTL

- N-to-1 arbiter for Caliptra's internal fabric (CIF) request/response handshake.
- Merges NUM_REQ CIF requesters onto one CIF responder port.
- Round-robin grant with optional burst locking: the grant holds until the beat with last=1 completes.
- Sits between fabric managers (DMA, AXI/AHB sub bridges) and shared MCI register/SRAM responders.

---
 rtl/cif_pkg.sv | 25 ++
 rtl/cif_rr_pick.sv | 28 ++
 rtl/cif_req_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cif_pkg.sv
// Shared widths and request-record layout for the CIF request/response fabric.
// A packed request, MSB to LSB: write, addr, wdata, wstrb, size, last, user, id.
package cif_pkg;

  localparam int CIF_ADDR_W_DEF = 32;
  localparam int CIF_DATA_W_DEF = 32;
  localparam int CIF_ID_W_DEF   = 8;
  localparam int CIF_USER_W_DEF = 32;

  localparam int CIF_WRITE_W = 1;
  localparam int CIF_SIZE_W  = 3;
  localparam int CIF_LAST_W  = 1;

  function automatic int cif_req_w(input int addr_w, input int data_w,
                                   input int user_w, input int id_w);
    return CIF_WRITE_W + addr_w + data_w + data_w / 8 + CIF_SIZE_W + CIF_LAST_W
           + user_w + id_w;
  endfunction

  // The last flag sits directly above the user and id fields.
  function automatic int cif_last_lsb(input int user_w, input int id_w);
    return user_w + id_w;
  endfunction

endpackage

// File: rtl/cif_rr_pick.sv
// Round-robin selector: returns the first set request at or after ptr, wrapping.
module cif_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    j   = 0;
    any = 1'b0;
    idx = '0;
    // Walk from farthest to nearest so the nearest hit from ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cif_req_arb.sv
// N-to-1 CIF request arbiter: round-robin grant, optionally held across a burst
// until the beat carrying last=1 completes.
module cif_req_arb
  import cif_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int ADDR_WIDTH   = CIF_ADDR_W_DEF,
  parameter  int DATA_WIDTH   = CIF_DATA_W_DEF,
  parameter  int ID_WIDTH     = CIF_ID_W_DEF,
  parameter  int USER_WIDTH   = CIF_USER_W_DEF,
  parameter  bit LOCK_ON_LAST = 1'b1,
  localparam int REQ_W        = cif_req_w(ADDR_WIDTH, DATA_WIDTH, USER_WIDTH, ID_WIDTH),
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_REQ-1:0]       up_dv,
  input  logic [NUM_REQ*REQ_W-1:0] up_req_data,
  output logic [NUM_REQ-1:0]       up_hold,
  output logic [DATA_WIDTH-1:0]    up_rdata,
  output logic [NUM_REQ-1:0]       up_error,
  output logic                     dn_dv,
  output logic [REQ_W-1:0]         dn_req_data,
  input  logic                     dn_hold,
  input  logic [DATA_WIDTH-1:0]    dn_rdata,
  input  logic                     dn_error,
  output logic                     grant_vld,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     proto_err
);

  localparam int LAST_LSB = cif_last_lsb(USER_WIDTH, ID_WIDTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             proto_err_q, proto_err_d;

  logic [REQ_W-1:0] req_arr [NUM_REQ];
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             busy, gnt_dv, beat_done, beat_last;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_arr[g] = up_req_data[g*REQ_W +: REQ_W];
  end

  cif_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (up_dv),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    busy        = (state_q == ST_BUSY);
    gnt_dv      = up_dv[grant_idx_q];
    dn_dv       = busy & gnt_dv;
    dn_req_data = busy ? req_arr[grant_idx_q] : '0;
    beat_done   = dn_dv & ~dn_hold;
    beat_last   = dn_req_data[LAST_LSB];
    up_hold     = '1;
    up_error    = '0;
    if (busy) begin
      up_hold[grant_idx_q]  = dn_hold;
      up_error[grant_idx_q] = dn_error & beat_done;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d     = ST_BUSY;
          grant_idx_d = pick_idx;
        end
      end
      ST_BUSY: begin
        // An owner that drops dv mid-transfer forfeits its turn without advancing rr_ptr.
        if (!gnt_dv) begin
          state_d     = ST_IDLE;
          proto_err_d = 1'b1;
        end else if (beat_done && (beat_last || !LOCK_ON_LAST)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign grant_vld = busy;
  assign grant_idx = grant_idx_q;
  assign proto_err = proto_err_q;
  assign up_rdata  = dn_rdata;

endmodule
